// File: rtl/flash_sample_reader.sv
// Flash audio playback reader: fetches one 32-bit word over Avalon-MM, plays both
// 16-bit halves on successive sample ticks, then pulses addr_advance to the address FSM.
module flash_sample_reader #(
    parameter int ADDR_W     = 23,
    parameter int SAMPLE_W   = 16,
    parameter int UNDERRUN_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sample_tick,
    input  logic                  backward,
    input  logic [ADDR_W-1:0]     address,
    output logic                  addr_advance,
    output logic                  flash_mem_read,
    output logic [ADDR_W-1:0]     flash_mem_address,
    output logic [3:0]            flash_mem_byteenable,
    input  logic                  flash_mem_waitrequest,
    input  logic                  flash_mem_readdatavalid,
    input  logic [2*SAMPLE_W-1:0] flash_mem_readdata,
    output logic [SAMPLE_W-1:0]   audio_sample,
    output logic                  sample_valid,
    output logic [UNDERRUN_W-1:0] underrun_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_PLAY1,
        S_PLAY2,
        S_ADV,
        S_SETTLE
    } state_t;

    state_t                r_state;
    logic [2*SAMPLE_W-1:0] r_word;
    logic                  r_bwd;
    logic                  r_drop;

    logic w_fetching;
    logic w_underrun;
    logic w_cnt_full;

    assign flash_mem_byteenable = 4'b1111;

    assign w_fetching = (r_state == S_REQ) || (r_state == S_WAIT_DATA)
                     || (r_state == S_ADV) || (r_state == S_SETTLE);
    assign w_underrun = sample_tick && enable && w_fetching;
    assign w_cnt_full = &underrun_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_word            <= '0;
            r_bwd             <= 1'b0;
            r_drop            <= 1'b0;
            addr_advance      <= 1'b0;
            flash_mem_read    <= 1'b0;
            flash_mem_address <= '0;
            audio_sample      <= '0;
            sample_valid      <= 1'b0;
            underrun_count    <= '0;
        end else begin
            sample_valid <= 1'b0;
            addr_advance <= 1'b0;

            if (w_underrun && !w_cnt_full)
                underrun_count <= underrun_count + 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_drop <= 1'b0;
                    if (enable) begin
                        flash_mem_address <= address;
                        flash_mem_read    <= 1'b1;
                        r_state           <= S_REQ;
                    end
                end

                // An accepted read cannot be aborted: losing enable only marks the data for dropping.
                S_REQ: begin
                    if (!enable)
                        r_drop <= 1'b1;
                    if (!flash_mem_waitrequest) begin
                        flash_mem_read <= 1'b0;
                        if (flash_mem_readdatavalid) begin
                            if (r_drop || !enable) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_word  <= flash_mem_readdata;
                                r_state <= S_PLAY1;
                            end
                        end else begin
                            r_state <= S_WAIT_DATA;
                        end
                    end
                end

                S_WAIT_DATA: begin
                    if (!enable)
                        r_drop <= 1'b1;
                    if (flash_mem_readdatavalid) begin
                        if (r_drop || !enable) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_word  <= flash_mem_readdata;
                            r_state <= S_PLAY1;
                        end
                    end
                end

                S_PLAY1: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (sample_tick) begin
                        audio_sample <= backward ? r_word[2*SAMPLE_W-1:SAMPLE_W]
                                                 : r_word[SAMPLE_W-1:0];
                        r_bwd        <= backward;
                        sample_valid <= 1'b1;
                        r_state      <= S_PLAY2;
                    end
                end

                S_PLAY2: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (sample_tick) begin
                        audio_sample <= r_bwd ? r_word[SAMPLE_W-1:0]
                                              : r_word[2*SAMPLE_W-1:SAMPLE_W];
                        sample_valid <= 1'b1;
                        addr_advance <= 1'b1;
                        r_state      <= S_ADV;
                    end
                end

                S_ADV: begin
                    r_state <= S_SETTLE;
                end

                // One spare cycle so the address FSM's new address is on the input before latching.
                S_SETTLE: begin
                    if (enable) begin
                        flash_mem_address <= address;
                        flash_mem_read    <= 1'b1;
                        r_drop            <= 1'b0;
                        r_state           <= S_REQ;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Bench for flash_sample_reader: Avalon slave model, queue-based sample model and
// address-FSM model checked every cycle, plus directed scenarios with literal expectations.
module tb_flash_sample_reader;

    localparam int ADDR_W     = 23;
    localparam int SAMPLE_W   = 16;
    localparam int UNDERRUN_W = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  enable = 1'b0;
    logic                  sample_tick = 1'b0;
    logic                  backward = 1'b0;
    logic [ADDR_W-1:0]     address = '0;
    logic                  addr_advance;
    logic                  flash_mem_read;
    logic [ADDR_W-1:0]     flash_mem_address;
    logic [3:0]            flash_mem_byteenable;
    logic                  flash_mem_waitrequest = 1'b0;
    logic                  flash_mem_readdatavalid = 1'b0;
    logic [2*SAMPLE_W-1:0] flash_mem_readdata = '0;
    logic [SAMPLE_W-1:0]   audio_sample;
    logic                  sample_valid;
    logic [UNDERRUN_W-1:0] underrun_count;

    always #10 clk = ~clk;

    flash_sample_reader #(
        .ADDR_W(ADDR_W),
        .SAMPLE_W(SAMPLE_W),
        .UNDERRUN_W(UNDERRUN_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sample_tick(sample_tick),
        .backward(backward),
        .address(address),
        .addr_advance(addr_advance),
        .flash_mem_read(flash_mem_read),
        .flash_mem_address(flash_mem_address),
        .flash_mem_byteenable(flash_mem_byteenable),
        .flash_mem_waitrequest(flash_mem_waitrequest),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .flash_mem_readdata(flash_mem_readdata),
        .audio_sample(audio_sample),
        .sample_valid(sample_valid),
        .underrun_count(underrun_count)
    );

    int checks = 0;
    int failures = 0;

    // slave configuration and state
    int          cfg_wait = 0;
    int          cfg_lat = 1;
    bit          cfg_fixed = 1'b1;
    logic [31:0] cfg_word = '0;
    bit          busy = 1'b0;
    int          wcnt = 0;
    bit          pend_act = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    int          accepts = 0;
    logic [ADDR_W-1:0] acc_addr[$];

    // playback model
    logic [31:0]       words_q[$];
    int                half = 0;
    bit                bwd_word = 1'b0;
    int                plays = 0;
    int                adv_count = 0;
    int                sv_count = 0;
    int                read_cycles = 0;
    logic [15:0]       last_sample = '0;
    bit                prev_read = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [ADDR_W-1:0] addr_base = '0;
    int                addr_off = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fire(input logic [31:0] d);
        flash_mem_readdata      = d;
        flash_mem_readdatavalid = 1'b1;
        pend_act                = 1'b0;
        words_q.push_back(d);
    endtask

    // Runs once per cycle after the falling edge: inputs still hold what the DUT sampled at
    // the last rising edge, outputs show its result.
    task automatic env();
        logic [15:0] exp;
        if (reset) begin
            busy = 1'b0; pend_act = 1'b0;
            flash_mem_waitrequest = 1'b0; flash_mem_readdatavalid = 1'b0;
            words_q.delete(); half = 0; plays = 0; last_sample = '0;
            prev_read = 1'b0; addr_off = 0;
            address = addr_base;
            return;
        end
        chk("byteenable", {28'd0, flash_mem_byteenable}, 32'hF);
        if (sample_valid) begin
            sv_count++;
            if (words_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sample_source: actual=sample_valid with no fetched word required=no sample_valid (t=%0t)", $time);
            end else begin
                if (half == 0) begin
                    bwd_word = backward;
                    exp = backward ? words_q[0][31:16] : words_q[0][15:0];
                    half = 1;
                end else begin
                    exp = bwd_word ? words_q[0][15:0] : words_q[0][31:16];
                    void'(words_q.pop_front());
                    half = 0;
                end
                chk("sample_value", {16'd0, audio_sample}, {16'd0, exp});
                last_sample = exp;
                plays++;
            end
        end else begin
            chk("sample_hold", {16'd0, audio_sample}, {16'd0, last_sample});
        end
        if (addr_advance) begin
            adv_count++;
            chk("adv_after_two_samples", plays, 2);
            plays = 0;
            addr_off++;
        end
        if (prev_read && flash_mem_waitrequest) begin
            chk("read_held", {31'd0, flash_mem_read}, 32'd1);
            chk("addr_held", {9'd0, flash_mem_address}, {9'd0, prev_addr});
        end
        if (flash_mem_read) read_cycles++;

        flash_mem_readdatavalid = 1'b0;
        if (pend_act) begin
            pend_cnt--;
            if (pend_cnt == 0) fire(pend_data);
        end
        if (flash_mem_read) begin
            if (!busy) begin busy = 1'b1; wcnt = cfg_wait; end
            if (wcnt > 0) begin
                flash_mem_waitrequest = 1'b1;
                wcnt--;
            end else begin
                flash_mem_waitrequest = 1'b0;
                busy = 1'b0;
                accepts++;
                acc_addr.push_back(flash_mem_address);
                pend_data = cfg_fixed ? cfg_word
                                      : {~flash_mem_address[15:0], flash_mem_address[15:0]};
                if (cfg_lat == 0) fire(pend_data);
                else begin pend_act = 1'b1; pend_cnt = cfg_lat; end
            end
        end else begin
            flash_mem_waitrequest = 1'b0;
        end
        prev_read = flash_mem_read;
        prev_addr = flash_mem_address;
        address = addr_base + ADDR_W'(addr_off);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        env();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic flush_model();
        words_q.delete();
        half = 0;
        plays = 0;
    endtask

    task automatic set_base(input logic [ADDR_W-1:0] b);
        addr_base = b;
        address = addr_base + ADDR_W'(addr_off);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; sample_tick = 1'b0; backward = 1'b0;
        cfg_wait = 0; cfg_lat = 1; cfg_fixed = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, rc0, adv0, sv0;

        // 1: forward playback
        do_reset();
        chk("rst_read", {31'd0, flash_mem_read}, 32'd0);
        chk("rst_address", {9'd0, flash_mem_address}, 32'd0);
        chk("rst_sample", {16'd0, audio_sample}, 32'd0);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_adv", {31'd0, addr_advance}, 32'd0);
        chk("rst_underrun", {24'd0, underrun_count}, 32'd0);
        cfg_word = 32'hBEEF1234; cfg_lat = 2; set_base(23'h10);
        acc0 = accepts; rc0 = read_cycles; adv0 = adv_count;
        enable = 1'b1;
        wait_cycles(6);
        chk("t1_accepts", accepts - acc0, 1);
        chk("t1_read_cycles", read_cycles - rc0, 1);
        chk("t1_addr", {9'd0, acc_addr[acc_addr.size()-1]}, 32'h10);
        tick();
        chk("t1_sample1", {16'd0, audio_sample}, 32'h1234);
        wait_cycles(2);
        tick();
        chk("t1_sample2", {16'd0, audio_sample}, 32'hBEEF);
        enable = 1'b0;
        wait_cycles(4);
        chk("t1_adv", adv_count - adv0, 1);
        chk("t1_no_refetch", accepts - acc0, 1);
        chk("t1_queue_empty", words_q.size(), 0);

        // 2: backward playback, data valid on the accept cycle
        do_reset();
        cfg_word = 32'hBEEF1234; cfg_lat = 0; set_base(23'h20);
        adv0 = adv_count;
        backward = 1'b1; enable = 1'b1;
        wait_cycles(4);
        tick();
        chk("t2_sample1", {16'd0, audio_sample}, 32'hBEEF);
        backward = 1'b0;
        wait_cycles(1);
        tick();
        chk("t2_sample2", {16'd0, audio_sample}, 32'h1234);
        enable = 1'b0;
        wait_cycles(4);
        chk("t2_adv", adv_count - adv0, 1);

        // 3: waitrequest held five cycles
        do_reset();
        cfg_word = 32'h5A5A0F0F; cfg_wait = 5; cfg_lat = 1; set_base(23'h55);
        acc0 = accepts; rc0 = read_cycles;
        enable = 1'b1;
        wait_cycles(10);
        chk("t3_read_cycles", read_cycles - rc0, 6);
        chk("t3_accepts", accepts - acc0, 1);
        chk("t3_addr", {9'd0, acc_addr[acc_addr.size()-1]}, 32'h55);
        tick(); wait_cycles(1); tick();
        chk("t3_sample2", {16'd0, audio_sample}, 32'h5A5A);
        enable = 1'b0;
        wait_cycles(4);

        // 4: ticks during a long stall are underruns
        do_reset();
        cfg_word = 32'h11112222; cfg_wait = 20; cfg_lat = 1; set_base(23'h60);
        sv0 = sv_count;
        enable = 1'b1;
        step();
        repeat (5) begin
            tick();
            wait_cycles(3);
        end
        chk("t4_underrun", {24'd0, underrun_count}, 32'd5);
        chk("t4_no_valid", sv_count - sv0, 0);
        chk("t4_sample_held", {16'd0, audio_sample}, 32'd0);
        enable = 1'b0;
        wait_cycles(8);
        flush_model();

        // 5a: enable dropped in PLAY2
        do_reset();
        cfg_word = 32'hCAFE0001; cfg_lat = 1; set_base(23'h30);
        adv0 = adv_count; sv0 = sv_count;
        enable = 1'b1;
        wait_cycles(5);
        tick();
        enable = 1'b0;
        flush_model();
        wait_cycles(3);
        tick(); wait_cycles(2); tick(); wait_cycles(2);
        chk("t5a_adv", adv_count - adv0, 0);
        chk("t5a_valid", sv_count - sv0, 1);
        chk("t5a_sample", {16'd0, audio_sample}, 32'h0001);
        chk("t5a_idle_no_underrun", {24'd0, underrun_count}, 32'd0);
        chk("t5a_idle_read", {31'd0, flash_mem_read}, 32'd0);

        // 5b: enable dropped in WAIT_DATA, data swallowed
        cfg_word = 32'hDEAD7777; cfg_lat = 4; set_base(23'h40);
        acc0 = accepts; sv0 = sv_count;
        enable = 1'b1;
        step(); step();
        enable = 1'b0;
        wait_cycles(8);
        flush_model();
        chk("t5b_accepts", accepts - acc0, 1);
        chk("t5b_no_valid", sv_count - sv0, 0);
        chk("t5b_sample", {16'd0, audio_sample}, 32'h0001);
        tick(); wait_cycles(1);
        chk("t5b_no_underrun", {24'd0, underrun_count}, 32'd0);
        set_base(23'h41);
        enable = 1'b1;
        step();
        chk("t5b_idle_restart_read", {31'd0, flash_mem_read}, 32'd1);
        chk("t5b_idle_restart_addr", {9'd0, flash_mem_address}, 32'h41);

        // 7: continuous playback across three words with address advance
        do_reset();
        cfg_fixed = 1'b0; cfg_lat = 1; set_base(23'h100);
        adv0 = adv_count; sv0 = sv_count;
        enable = 1'b1;
        wait_cycles(5);
        tick();
        chk("t7_first_sample", {16'd0, audio_sample}, 32'h0100);
        wait_cycles(2); tick();
        wait_cycles(6);
        backward = 1'b1;
        tick(); backward = 1'b0;
        wait_cycles(2); tick();
        tick(); tick();
        chk("t7_adv_settle_underruns", {24'd0, underrun_count}, 32'd2);
        wait_cycles(4);
        tick(); wait_cycles(2); tick();
        enable = 1'b0;
        wait_cycles(4);
        chk("t7_adv", adv_count - adv0, 3);
        chk("t7_valid", sv_count - sv0, 6);
        chk("t7_addr0", {9'd0, acc_addr[acc_addr.size()-3]}, 32'h100);
        chk("t7_addr1", {9'd0, acc_addr[acc_addr.size()-2]}, 32'h101);
        chk("t7_addr2", {9'd0, acc_addr[acc_addr.size()-1]}, 32'h102);
        chk("t7_queue_empty", words_q.size(), 0);

        // 6: saturation, then asynchronous reset mid-REQ
        do_reset();
        cfg_wait = 1000; set_base(23'h70);
        enable = 1'b1;
        step();
        repeat (300) begin
            tick();
            step();
        end
        chk("t6_saturated", {24'd0, underrun_count}, 32'd255);
        chk("t6_in_req", {31'd0, flash_mem_read}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_async_read", {31'd0, flash_mem_read}, 32'd0);
        chk("t6_async_underrun", {24'd0, underrun_count}, 32'd0);
        chk("t6_async_addr", {9'd0, flash_mem_address}, 32'd0);
        enable = 1'b0;
        step(); step();
        reset = 1'b0;
        cfg_wait = 0;
        step();
        chk("t6_idle_read", {31'd0, flash_mem_read}, 32'd0);
        enable = 1'b1;
        step();
        chk("t6_restart_read", {31'd0, flash_mem_read}, 32'd1);
        enable = 1'b0;
        wait_cycles(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
